// File: rtl/stavka_pkg.sv
// Shared opcodes, control words and FSM state type for the two-requester
// command sequencer.
package stavka_pkg;

   localparam int DATA_W_DEF = 4;

   localparam logic [1:0] CMD_LOAD  = 2'b00;
   localparam logic [1:0] CMD_LOAD2 = 2'b01;
   localparam logic [1:0] CMD_INC   = 2'b10;
   localparam logic [1:0] CMD_WAIT  = 2'b11;

   localparam logic [2:0] CTRL_IDLE  = 3'b000;
   localparam logic [2:0] CTRL_LOAD  = 3'b001;
   localparam logic [2:0] CTRL_LOAD2 = 3'b011;
   localparam logic [2:0] CTRL_INC   = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // LOAD and LOAD2 always issue exactly one word; the others repeat N times.
   function automatic logic is_single(input logic [1:0] cmd);
      return (cmd == CMD_LOAD) || (cmd == CMD_LOAD2);
   endfunction

endpackage

// File: rtl/stavka_c_sequencer_rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last
// time is granted. Grant is one-hot and only asserted while en is high.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_id,
   input  logic       en,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (en) begin
         if (req == 2'b11) begin
            grant = last_id ? 2'b01 : 2'b10;
         end else begin
            grant = req;
         end
      end
   end

endmodule

// File: rtl/stavka_c_sequencer.sv
// Command sequencer: arbitrates requesters A/B and expands each accepted
// command into a timed run of datapath control words.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | waiting for a request; ready goes to the granted requester
//   ST_EXEC | driving control words, counter counts down to 1
//   ST_DONE | one-cycle done pulse tagged with the requester id
module stavka_c_sequencer
   import stavka_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [1:0]        a_cmd,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [1:0]        b_cmd,
   input  logic [DATA_W-1:0] b_data,
   output logic [2:0]        ctrl_out,
   output logic [DATA_W-1:0] data_out,
   output logic              busy,
   output logic              done,
   output logic              done_id
);

   state_t            state_q, state_d;
   logic [1:0]        grant;
   logic [DATA_W-1:0] cnt_q;
   logic [DATA_W-1:0] data_q;
   logic [1:0]        cmd_q;
   logic              id_q;
   logic              last_id_q;

   logic              accept;
   logic              sel_id;
   logic [1:0]        sel_cmd;
   logic [DATA_W-1:0] sel_data;
   logic [DATA_W-1:0] load_cnt;

   rr_arbiter2 u_arb (
      .req     ({b_valid, a_valid}),
      .last_id (last_id_q),
      .en      (state_q == ST_IDLE),
      .grant   (grant)
   );

   assign a_ready  = grant[0];
   assign b_ready  = grant[1];
   assign accept   = |grant;
   assign sel_id   = grant[1];
   assign sel_cmd  = sel_id ? b_cmd  : a_cmd;
   assign sel_data = sel_id ? b_data : a_data;
   assign load_cnt = is_single(sel_cmd) ? DATA_W'(1) : sel_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = (load_cnt != '0) ? ST_EXEC : ST_DONE;
            end
         end
         ST_EXEC: begin
            if (cnt_q == DATA_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         data_q    <= '0;
         cmd_q     <= CMD_LOAD;
         id_q      <= 1'b0;
         last_id_q <= 1'b1;
      end else begin
         if ((state_q == ST_IDLE) && accept) begin
            cnt_q  <= load_cnt;
            data_q <= sel_data;
            cmd_q  <= sel_cmd;
            id_q   <= sel_id;
         end else if (state_q == ST_EXEC) begin
            cnt_q <= cnt_q - DATA_W'(1);
         end
         if (state_q == ST_DONE) begin
            last_id_q <= id_q;
         end
      end
   end

   // Datapath drive is decoded purely from registered state.
   always_comb begin
      ctrl_out = CTRL_IDLE;
      data_out = '0;
      if (state_q == ST_EXEC) begin
         unique case (cmd_q)
            CMD_LOAD: begin
               ctrl_out = CTRL_LOAD;
               data_out = data_q;
            end
            CMD_LOAD2: begin
               ctrl_out = CTRL_LOAD2;
               data_out = data_q;
            end
            CMD_INC:  ctrl_out = CTRL_INC;
            default:  ctrl_out = CTRL_IDLE;
         endcase
      end
   end

   assign busy    = (state_q != ST_IDLE);
   assign done    = (state_q == ST_DONE);
   assign done_id = (state_q == ST_DONE) && id_q;

endmodule

// File: tb/tb_stavka_c_sequencer.sv
// Directed bench for stavka_c_sequencer driving a behavioural model of the
// 4-bit load/double/increment register datapath.
module tb_stavka_c_sequencer;

   logic       clk;
   logic       rst;
   logic       a_valid, b_valid;
   logic       a_ready, b_ready;
   logic [1:0] a_cmd, b_cmd;
   logic [3:0] a_data, b_data;
   logic [2:0] ctrl_out;
   logic [3:0] data_out;
   logic       busy, done, done_id;

   logic       dp_rst_n;
   logic [3:0] dp_reg;

   int n_checks = 0;
   int n_errors = 0;

   stavka_c_sequencer #(.DATA_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .a_cmd    (a_cmd),
      .a_data   (a_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_cmd    (b_cmd),
      .b_data   (b_data),
      .ctrl_out (ctrl_out),
      .data_out (data_out),
      .busy     (busy),
      .done     (done),
      .done_id  (done_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register datapath: bit0 enable, bit1 double, bit2 increment.
   assign dp_rst_n = ~rst;
   always @(posedge clk or negedge dp_rst_n) begin
      if (!dp_rst_n) begin
         dp_reg <= 4'h0;
      end else if (ctrl_out[0]) begin
         if (ctrl_out[2])      dp_reg <= dp_reg + 4'h1;
         else if (ctrl_out[1]) dp_reg <= {data_out[2:0], 1'b0};
         else                  dp_reg <= data_out;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one command, then follow it word by word through done.
   task automatic send(input logic id, input logic [1:0] cmd, input logic [3:0] data,
                       input logic [2:0] exp_ctrl, input logic [3:0] exp_data, input int k);
      int n;
      if (id) begin
         b_valid = 1'b1; b_cmd = cmd; b_data = data;
      end else begin
         a_valid = 1'b1; a_cmd = cmd; a_data = data;
      end
      @(negedge clk);
      n = 0;
      while (!(id ? b_ready : a_ready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ready", id ? b_ready : a_ready, 1'b1);
      check("other_ready", id ? a_ready : b_ready, 1'b0);
      @(posedge clk); #1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      for (int i = 0; i < k; i++) begin
         @(negedge clk);
         check("ctrl", ctrl_out, exp_ctrl);
         check("data_out", data_out, exp_data);
         check("busy_exec", busy, 1'b1);
         check("no_done_exec", done, 1'b0);
      end
      @(negedge clk);
      check("done", done, 1'b1);
      check("done_id", done_id, id);
      check("ctrl_done", ctrl_out, 3'b000);
      check("busy_done", busy, 1'b1);
      @(posedge clk); #1;
      check("idle_busy", busy, 1'b0);
   endtask

   initial begin
      logic ids [3];
      int   n_done;
      rst = 1'b1;
      a_valid = 1'b0; a_cmd = 2'b00; a_data = 4'h0;
      b_valid = 1'b0; b_cmd = 2'b00; b_data = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ctrl", ctrl_out, 3'b000);
      check("rst_data", data_out, 4'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_a_ready", a_ready, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;

      send(1'b0, 2'b00, 4'h9, 3'b001, 4'h9, 1);
      check("reg_load9", dp_reg, 4'h9);
      send(1'b0, 2'b01, 4'hB, 3'b011, 4'hB, 1);
      check("reg_load2", dp_reg, 4'h6);
      send(1'b0, 2'b00, 4'hE, 3'b001, 4'hE, 1);
      send(1'b0, 2'b10, 4'd3, 3'b101, 4'h0, 3);
      check("reg_inc_wrap", dp_reg, 4'h1);
      send(1'b0, 2'b10, 4'd0, 3'b000, 4'h0, 0);
      check("reg_inc0", dp_reg, 4'h1);
      send(1'b0, 2'b11, 4'd5, 3'b000, 4'h0, 5);
      check("reg_wait", dp_reg, 4'h1);
      send(1'b1, 2'b00, 4'h7, 3'b001, 4'h7, 1);
      check("reg_b_load", dp_reg, 4'h7);

      // INC_N 8 interrupted by reset after three words.
      a_valid = 1'b1; a_cmd = 2'b10; a_data = 4'd8;
      @(negedge clk);
      check("inc8_ready", a_ready, 1'b1);
      @(posedge clk); #1;
      a_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("inc8_reg", dp_reg, 4'hA);
      check("inc8_ctrl", ctrl_out, 3'b101);
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_ctrl", ctrl_out, 3'b000);
      check("mid_rst_data", data_out, 4'h0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_done", done, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("dropped_no_done", done, 1'b0);
      end
      @(posedge clk); #1;

      // Both requesters held valid: grants alternate starting with A.
      a_valid = 1'b1; a_cmd = 2'b00; a_data = 4'h1;
      b_valid = 1'b1; b_cmd = 2'b00; b_data = 4'h2;
      n_done = 0;
      for (int i = 0; i < 40 && n_done < 3; i++) begin
         @(negedge clk);
         if (done) begin
            ids[n_done] = done_id;
            n_done++;
         end
      end
      @(posedge clk); #1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      check("tie_count", n_done, 3);
      if (n_done == 3) begin
         check("tie_id0", ids[0], 1'b0);
         check("tie_id1", ids[1], 1'b1);
         check("tie_id2", ids[2], 1'b0);
      end
      check("tie_reg", dp_reg, 4'h1);
      repeat (2) @(negedge clk);
      check("tie_idle_busy", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
